voice_allocator: RTL
====================

# voice_allocator

Polyphonic voice allocator that sits between the MIDI event decoder and a bank of `VOICES` nco instances. It accepts note-on/note-off events over a valid/ready handshake and assigns each note to a voice slot, driving per-voice note number, velocity and gate. Allocation order is: retrigger a slot already holding the same note, then the lowest-index free slot, then the oldest sounding slot (stealing). It owns the per-voice `NOTE_NUM`/`NOTE_VEL` configuration of the nco bank.

## Interface
- `VOICES`, default 4: number of voice slots, 2..16.
- `AGE_W`, default 4: age-rank width; must satisfy 2^AGE_W >= VOICES.
- `CLK`  in  1  system clock.
- `RST`  in  1  asynchronous, active-high reset.
- `CE`  in  1  clock enable; all state advances only when CE=1.
- `EV_VALID`  in  1  event present.
- `EV_READY`  out  1  allocator can accept an event.
- `EV_ON`  in  1  1 = note-on, 0 = note-off.
- `EV_NOTE`  in  7  MIDI note number.
- `EV_VEL`  in  7  MIDI velocity.
- `VOICE_NOTE`  out  7*VOICES  note per slot, slot i at [7i+6:7i].
- `VOICE_VEL`  out  7*VOICES  velocity per slot.
- `VOICE_GATE`  out  VOICES  slot sounding.
- `DROP`  out  1  one-cycle pulse when a note-on is discarded.

## Operation
- Reset: state IDLE, all `VOICE_NOTE`/`VOICE_VEL`/`VOICE_GATE`/ages = 0, `DROP` = 0.
- `EV_READY` = (state == IDLE), so it is 1 during and after reset. An event is accepted on a CE edge with `EV_VALID & EV_READY`. `EV_NOTE`, `EV_VEL` and `EV_ON` are latched at acceptance. A note-on with `EV_VEL` = 0 is latched as a note-off.
- FSM: IDLE -> SCAN on acceptance. SCAN visits slot index 0..VOICES-1, one per CE cycle, then goes to APPLY. APPLY commits for one CE cycle and returns to IDLE.
- SCAN records:
  - the first gated slot with a matching note (hit);
  - the first ungated slot (free);
  - the gated slot with the maximum age (oldest). Ties go to the lowest index, using strict > compare in scan order.
- APPLY for note-on:
  - hit: update the velocity and set that slot's age to 0.
  - otherwise free: write note and velocity, set gate, set age to 0.
  - otherwise steal, with the macro enabled: overwrite the oldest slot in the same way.
  - otherwise: assert `DROP`; no slot changes.
- Aging: on any committed note-on, every other gated slot increments its age, saturating at VOICES-1.
- APPLY for note-off:
  - hit: clear gate. `VOICE_NOTE`/`VOICE_VEL` hold their last values.
  - miss: no change, no `DROP`.
- Retrigger guarantees at most one gated slot per note number.
- `RST` mid-SCAN or mid-APPLY aborts the event with no commit and returns all registers to their reset values.

## Timing
- Acceptance edge = cycle 0. SCAN occupies CE cycles 1..VOICES. Outputs and `DROP` update on the APPLY edge (cycle VOICES+1).
- `EV_READY` rises in the cycle after APPLY. Event-to-event throughput is VOICES+2 CE cycles.
- With CE=0 the FSM, the scan index and all outputs freeze. `DROP` stays high only for its one APPLY cycle; it is cleared on the next CE edge.
- Outputs are registered, with no combinational path from `EV_*` to `VOICE_*`. `EV_READY` is decoded from state only.

## Configuration
- `VOICE_STEAL_EN` defined: a note-on with no hit and no free slot steals the oldest gated slot. `DROP` never asserts.
- Undefined: that note-on asserts `DROP` and is discarded. The oldest-slot tracking logic is not synthesized; ages are still kept for any future priority use.

## Structure
- Shared package `synth_pkg`:
  - `NOTE_W` = 7, `VEL_W` = 7;
  - the `alloc_state_t` enum {IDLE, SCAN, APPLY};
  - the `ev_t` struct {on, note, vel}.
- One sub-module `voice_slot`: the per-slot note, velocity, gate and age registers, with write/clear/age-increment controls. It is instantiated VOICES times.
- The allocator top holds the FSM, the scan index counter and the hit/free/oldest trackers.

## Test plan
- Reset, then note-ons 60/100, 62/90, 64/80, 65/70 -> slots 0..3 gated with those notes; ages 3,2,1,0; each event takes 6 cycles at CE=1.
- From the full state, note-on 67/50 -> with `VOICE_STEAL_EN`: slot 0 = 67/50, ages 0,3,2,1, `DROP` = 0. Without it: no change, one `DROP` pulse.
- Note-off 62 -> slot 1 gate = 0, note still 62, others unchanged. Then note-off 70 -> no change, no `DROP`.
- Note-on 64/127 while 64 is held -> slot 2 velocity = 127, no other slot written, slot 2 age = 0.
- Note-on 61 with velocity 0 while 61 is held in slot 0 -> treated as note-off; slot 0 gate clears.
- Assert `RST` during SCAN (cycle 2) -> all outputs 0 and `EV_READY` = 1 immediately. Toggling CE=0 mid-SCAN stretches latency by exactly the stalled cycles.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared types and widths for the synth voice path (allocator, voice slots).
package synth_pkg;

  localparam int NOTE_W = 7;
  localparam int VEL_W  = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    APPLY = 2'd2
  } alloc_state_t;

  typedef struct packed {
    logic              on;
    logic [NOTE_W-1:0] note;
    logic [VEL_W-1:0]  vel;
  } ev_t;

endpackage

// File: rtl/voice_slot.sv
// One voice slot: note, velocity, gate and age-rank registers.
// Controls are mutually exclusive in practice; priority is write > vel > clear > age.
module voice_slot
  import synth_pkg::*;
#(
  parameter int AGE_W   = 4,
  parameter int AGE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              wr_note,
  input  logic              wr_vel,
  input  logic              clr_gate,
  input  logic              age_inc,
  input  logic [NOTE_W-1:0] note_in,
  input  logic [VEL_W-1:0]  vel_in,
  output logic [NOTE_W-1:0] note,
  output logic [VEL_W-1:0]  vel,
  output logic              gate,
  output logic [AGE_W-1:0]  age
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note <= '0;
      vel  <= '0;
      gate <= 1'b0;
      age  <= '0;
    end else if (ce) begin
      if (wr_note) begin
        note <= note_in;
        vel  <= vel_in;
        gate <= 1'b1;
        age  <= '0;
      end else if (wr_vel) begin
        vel <= vel_in;
        age <= '0;
      end else if (clr_gate) begin
        gate <= 1'b0;
      end else if (age_inc && (age < AGE_W'(AGE_MAX))) begin
        age <= age + AGE_W'(1);
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: retrigger, else lowest free slot, else steal oldest.
// Stealing is built only with VOICE_STEAL_EN defined; otherwise a full bank drops the note-on.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int VOICES = 4,
  parameter int AGE_W  = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CE,
  input  logic                     EV_VALID,
  output logic                     EV_READY,
  input  logic                     EV_ON,
  input  logic [NOTE_W-1:0]        EV_NOTE,
  input  logic [VEL_W-1:0]         EV_VEL,
  output logic [NOTE_W*VOICES-1:0] VOICE_NOTE,
  output logic [VEL_W*VOICES-1:0]  VOICE_VEL,
  output logic [VOICES-1:0]        VOICE_GATE,
  output logic                     DROP,
  output alloc_state_t             dbg_state,
  output logic [AGE_W*VOICES-1:0]  dbg_age
);

  localparam int IDX_W = $clog2(VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VOICES - 1);

  alloc_state_t state, state_next;
  ev_t ev_q;
  logic [IDX_W-1:0] idx;
  logic hit_found, free_found;
  logic [IDX_W-1:0] hit_idx, free_idx;

  logic [NOTE_W-1:0] slot_note [VOICES];
  logic [VEL_W-1:0]  slot_vel  [VOICES];
  logic [AGE_W-1:0]  slot_age  [VOICES];
  logic [VOICES-1:0] slot_gate;
  logic [VOICES-1:0] wr_note, wr_vel, clr_gate, age_inc;
  logic do_drop;

  logic cur_gate;
  logic [NOTE_W-1:0] cur_note;
  assign cur_gate = slot_gate[idx];
  assign cur_note = slot_note[idx];

`ifdef VOICE_STEAL_EN
  logic old_found;
  logic [IDX_W-1:0] old_idx;
  logic [AGE_W-1:0] old_age;
  logic [AGE_W-1:0] cur_age;
  assign cur_age = slot_age[idx];
`endif

  // Handshake: EV_READY is high only in IDLE; an event transfers on a CE edge
  // with EV_VALID & EV_READY, and EV_* are latched on that edge.
  assign EV_READY  = (state == IDLE);
  assign dbg_state = state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else if (CE) state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (EV_VALID) state_next = SCAN;
      SCAN:    if (idx == LAST_IDX) state_next = APPLY;
      APPLY:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ev_q       <= '0;
      idx        <= '0;
      hit_found  <= 1'b0;
      free_found <= 1'b0;
      hit_idx    <= '0;
      free_idx   <= '0;
      DROP       <= 1'b0;
`ifdef VOICE_STEAL_EN
      old_found  <= 1'b0;
      old_idx    <= '0;
      old_age    <= '0;
`endif
    end else if (CE) begin
      DROP <= do_drop;
      if (state == IDLE && EV_VALID) begin
        // Zero-velocity note-on is a note-off in MIDI running-status practice.
        ev_q.on    <= EV_ON && (EV_VEL != '0);
        ev_q.note  <= EV_NOTE;
        ev_q.vel   <= EV_VEL;
        idx        <= '0;
        hit_found  <= 1'b0;
        free_found <= 1'b0;
`ifdef VOICE_STEAL_EN
        old_found  <= 1'b0;
`endif
      end else if (state == SCAN) begin
        idx <= idx + IDX_W'(1);
        if (cur_gate && (cur_note == ev_q.note) && !hit_found) begin
          hit_found <= 1'b1;
          hit_idx   <= idx;
        end
        if (!cur_gate && !free_found) begin
          free_found <= 1'b1;
          free_idx   <= idx;
        end
`ifdef VOICE_STEAL_EN
        // Strict > keeps the lowest index among equally old slots.
        if (cur_gate && (!old_found || (cur_age > old_age))) begin
          old_found <= 1'b1;
          old_idx   <= idx;
          old_age   <= cur_age;
        end
`endif
      end
    end
  end

  always_comb begin
    logic commit_on;
    logic [IDX_W-1:0] tgt;
    commit_on = 1'b0;
    tgt       = '0;
    do_drop   = 1'b0;
    wr_note   = '0;
    wr_vel    = '0;
    clr_gate  = '0;
    age_inc   = '0;
    if (state == APPLY) begin
      if (ev_q.on) begin
        if (hit_found) begin
          wr_vel[hit_idx] = 1'b1;
          tgt             = hit_idx;
          commit_on       = 1'b1;
        end else if (free_found) begin
          wr_note[free_idx] = 1'b1;
          tgt               = free_idx;
          commit_on         = 1'b1;
`ifdef VOICE_STEAL_EN
        end else if (old_found) begin
          wr_note[old_idx] = 1'b1;
          tgt              = old_idx;
          commit_on        = 1'b1;
`endif
        end else begin
          do_drop = 1'b1;
        end
        if (commit_on) begin
          for (int i = 0; i < VOICES; i++) begin
            age_inc[i] = slot_gate[i] && (IDX_W'(i) != tgt);
          end
        end
      end else if (hit_found) begin
        clr_gate[hit_idx] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < VOICES; g++) begin : g_slot
    voice_slot #(
      .AGE_W   (AGE_W),
      .AGE_MAX (VOICES - 1)
    ) u_slot (
      .clk      (CLK),
      .rst      (RST),
      .ce       (CE),
      .wr_note  (wr_note[g]),
      .wr_vel   (wr_vel[g]),
      .clr_gate (clr_gate[g]),
      .age_inc  (age_inc[g]),
      .note_in  (ev_q.note),
      .vel_in   (ev_q.vel),
      .note     (slot_note[g]),
      .vel      (slot_vel[g]),
      .gate     (slot_gate[g]),
      .age      (slot_age[g])
    );
    assign VOICE_NOTE[g*NOTE_W +: NOTE_W] = slot_note[g];
    assign VOICE_VEL[g*VEL_W +: VEL_W]    = slot_vel[g];
    assign dbg_age[g*AGE_W +: AGE_W]      = slot_age[g];
  end

  assign VOICE_GATE = slot_gate;

endmodule
